// File: rtl/rf_port_arbiter.sv
// rf_port_arbiter
//   Shares one register file (1 write port, 2 registered read ports) among
//   NUM_REQ requesters using round-robin arbitration. It grants one write and
//   up to two reads per cycle. The write is driven straight onto the register
//   file pins. Read data returns to the granted requester one cycle later,
//   qualified by rd_valid.
//
//   Optional build macro: RF_BYPASS_EN
//     When defined, a read granted in the same cycle as a write to the same
//     address returns the newly written data instead of the pre-write value.
//
// Ports
//   CGRA_Clock, CGRA_Reset_n      clock, asynchronous active-low reset
//   wr_req / wr_addr / wr_data    per-requester write request, packed addr/data
//   wr_gnt                        one-hot write grant (combinational)
//   rd_req / rd_addr              per-requester read request, packed addr
//   rd_gnt                        read grant, at most two bits (combinational)
//   rd_valid / rd_rdata           read return, one cycle after grant
//   WE0, address_in0, in0         register-file write port
//   address_out0, address_out1    register-file read addresses
//   out0, out1                    register-file read data (registered in RF)

module rf_port_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int log2regs = 1,
    parameter int size     = 32
) (
    input  logic                         CGRA_Clock,
    input  logic                         CGRA_Reset_n,
    input  logic [NUM_REQ-1:0]           wr_req,
    input  logic [NUM_REQ*log2regs-1:0]  wr_addr,
    input  logic [NUM_REQ*size-1:0]      wr_data,
    output logic [NUM_REQ-1:0]           wr_gnt,
    input  logic [NUM_REQ-1:0]           rd_req,
    input  logic [NUM_REQ*log2regs-1:0]  rd_addr,
    output logic [NUM_REQ-1:0]           rd_gnt,
    output logic [NUM_REQ-1:0]           rd_valid,
    output logic [NUM_REQ*size-1:0]      rd_rdata,
    output logic                         WE0,
    output logic [log2regs-1:0]          address_in0,
    output logic [size-1:0]              in0,
    output logic [log2regs-1:0]          address_out0,
    output logic [log2regs-1:0]          address_out1,
    input  logic [size-1:0]              out0,
    input  logic [size-1:0]              out1
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

    // Unpacked views of the packed per-requester buses.
    logic [log2regs-1:0] wa [NUM_REQ];
    logic [log2regs-1:0] ra [NUM_REQ];
    logic [size-1:0]     wd [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign wa[g] = wr_addr[g*log2regs +: log2regs];
        assign ra[g] = rd_addr[g*log2regs +: log2regs];
        assign wd[g] = wr_data[g*size +: size];
    end

    function automatic logic [IW-1:0] inc_idx(input logic [IW-1:0] x);
        return (x == LAST) ? '0 : x + 1'b1;
    endfunction

    // Round-robin search starting at 'start'. The optional exclusion keeps the
    // second read winner distinct from the first. Returns {found, index}.
    function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                            input logic [IW-1:0]      start,
                                            input logic               use_excl,
                                            input logic [IW-1:0]      excl);
        logic [IW:0]   r;
        logic [IW-1:0] cur;
        r   = '0;
        cur = start;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!r[IW] && req[cur] && !(use_excl && cur == excl)) begin
                r = {1'b1, cur};
            end
            cur = inc_idx(cur);
        end
        return r;
    endfunction

    logic [IW-1:0] wptr, rptr;
    logic [IW-1:0] tag0, tag1;
    logic          tv0, tv1;

    logic [IW:0]   wr_pick, a_pick, b_pick;
    logic          wr_found, a_found, b_found;
    logic [IW-1:0] wr_win, a_win, b_win;

    assign wr_pick = rr_pick(wr_req, wptr, 1'b0, '0);
    assign a_pick  = rr_pick(rd_req, rptr, 1'b0, '0);
    assign b_pick  = rr_pick(rd_req, inc_idx(a_win), 1'b1, a_win);

    // Reset gates every grant so nothing transfers while reset is held.
    assign wr_found = wr_pick[IW] & CGRA_Reset_n;
    assign wr_win   = wr_pick[IW-1:0];
    assign a_found  = a_pick[IW] & CGRA_Reset_n;
    assign a_win    = a_pick[IW-1:0];
    assign b_found  = b_pick[IW] & a_found;
    assign b_win    = b_pick[IW-1:0];

    always_comb begin
        wr_gnt = '0;
        rd_gnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (wr_found && wr_win == IW'(i)) wr_gnt[i] = 1'b1;
            if ((a_found && a_win == IW'(i)) || (b_found && b_win == IW'(i))) rd_gnt[i] = 1'b1;
        end
    end

    assign WE0          = wr_found;
    assign address_in0  = wr_found ? wa[wr_win] : '0;
    assign in0          = wr_found ? wd[wr_win] : '0;
    assign address_out0 = a_found  ? ra[a_win]  : '0;
    assign address_out1 = b_found  ? ra[b_win]  : '0;

    // Grant edge: advance pointers and record where the read data must return.
    always_ff @(posedge CGRA_Clock or negedge CGRA_Reset_n) begin
        if (!CGRA_Reset_n) begin
            wptr <= '0;
            rptr <= '0;
            tag0 <= '0;
            tag1 <= '0;
            tv0  <= 1'b0;
            tv1  <= 1'b0;
        end else begin
            if (wr_found) wptr <= inc_idx(wr_win);
            if (b_found)      rptr <= inc_idx(b_win);
            else if (a_found) rptr <= inc_idx(a_win);
            tag0 <= a_win;
            tag1 <= b_win;
            tv0  <= a_found;
            tv1  <= b_found;
        end
    end

    logic [size-1:0] ret0, ret1;

`ifdef RF_BYPASS_EN
    logic            hit0, hit1;
    logic [size-1:0] wdata_p1;

    always_ff @(posedge CGRA_Clock or negedge CGRA_Reset_n) begin
        if (!CGRA_Reset_n) begin
            hit0 <= 1'b0;
            hit1 <= 1'b0;
        end else begin
            hit0 <= wr_found && a_found && (ra[a_win] == wa[wr_win]);
            hit1 <= wr_found && b_found && (ra[b_win] == wa[wr_win]);
        end
    end

    always_ff @(posedge CGRA_Clock) begin
        wdata_p1 <= in0;
    end

    assign ret0 = hit0 ? wdata_p1 : out0;
    assign ret1 = hit1 ? wdata_p1 : out1;
`else
    assign ret0 = out0;
    assign ret1 = out1;
`endif

    // Return stage: steer port data to the tagged requesters; others read 0.
    always_comb begin
        rd_valid = '0;
        rd_rdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (tv0 && tag0 == IW'(i)) begin
                rd_valid[i]              = 1'b1;
                rd_rdata[i*size +: size] = ret0;
            end
            if (tv1 && tag1 == IW'(i)) begin
                rd_valid[i]              = 1'b1;
                rd_rdata[i*size +: size] = ret1;
            end
        end
    end

endmodule
